// File: rtl/cnn_param_pkg.sv
// Shared definitions for the CNN parameter store: store state encoding and
// layer-index sizing used by the top level and the bench.
package cnn_param_pkg;
  typedef enum logic [1:0] {
    OPEN    = 2'd0,
    LOCKED  = 2'd1,
    ZEROIZE = 2'd2
  } state_e;

  localparam int NUM_LAYERS_DEF = 24;
  localparam int LAYER_W        = 6;
endpackage

// File: rtl/cnn_param_ram.sv
// Byte RAM with one write port and one registered read port (read-first),
// written so synthesis maps it onto block RAM.
module cnn_param_ram #(
  parameter int DEPTH = 65536,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/cnn_param_store.sv
// Weight-fetch responder: per-layer base/length windows over a byte RAM,
// bounds-checked reads, and an OPEN/LOCKED/ZEROIZE lifecycle.
module cnn_param_store #(
  parameter int NUM_LAYERS = cnn_param_pkg::NUM_LAYERS_DEF,
  parameter int MEM_DEPTH  = 65536,
  parameter int ADDR_W     = 18,
  localparam int PHYS_W    = $clog2(MEM_DEPTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rd_en,
  input  logic [cnn_param_pkg::LAYER_W-1:0] layer_select,
  input  logic [ADDR_W-1:0]                addr,
  output logic [7:0]                       data_out,
  output logic                             rd_valid,
  output logic                             rd_err,
  input  logic                             tbl_we,
  input  logic [cnn_param_pkg::LAYER_W-1:0] tbl_layer,
  input  logic [PHYS_W-1:0]                tbl_base,
  input  logic [PHYS_W:0]                  tbl_len,
  input  logic                             ld_we,
  input  logic [PHYS_W-1:0]                ld_addr,
  input  logic [7:0]                       ld_data,
  input  logic                             lock,
  input  logic                             zeroize,
  output logic                             locked,
  output logic                             busy,
  output logic                             wr_reject
);
  import cnn_param_pkg::*;

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int SUM_W = PHYS_W + ADDR_W + 1;
  localparam logic [SUM_W-1:0]  DEPTH_X    = SUM_W'(MEM_DEPTH);
  localparam logic [PHYS_W-1:0] SWEEP_LAST = PHYS_W'(MEM_DEPTH - 1);

  state_e            r_state;
  logic [PHYS_W-1:0] r_sweep;
  logic              r_locked, r_busy, r_wr_reject;
  logic              r_vld_p1, r_err_p1;
  logic [PHYS_W-1:0] r_base [NUM_LAYERS];
  logic [PHYS_W:0]   r_len  [NUM_LAYERS];

  logic              w_rd_layer_ok, w_rd_err, w_ram_re;
  logic [IDX_W-1:0]  w_rd_idx, w_tbl_idx;
  logic [SUM_W-1:0]  w_base_x, w_len_x, w_addr_x, w_phys;
  logic              w_tbl_ok, w_ld_ok, w_reject, w_zero;
  logic              w_ram_we;
  logic [PHYS_W-1:0] w_ram_waddr;
  logic [7:0]        w_ram_wdata, w_ram_q;

  assign w_zero = (r_state == ZEROIZE);

  // Read request decode: window lookup and bounds check, all at full width
  assign w_rd_layer_ok = 32'(layer_select) < NUM_LAYERS;
  assign w_rd_idx      = w_rd_layer_ok ? layer_select[IDX_W-1:0] : '0;
  assign w_base_x      = SUM_W'(r_base[w_rd_idx]);
  assign w_len_x       = SUM_W'(r_len[w_rd_idx]);
  assign w_addr_x      = SUM_W'(addr);
  assign w_phys        = w_base_x + w_addr_x;
  assign w_rd_err      = !w_rd_layer_ok || (w_addr_x >= w_len_x) ||
                         (w_phys >= DEPTH_X) || w_zero;
  assign w_ram_re      = rd_en && !w_rd_err;

  assign w_tbl_ok  = tbl_we && (r_state == OPEN) && (32'(tbl_layer) < NUM_LAYERS);
  assign w_tbl_idx = tbl_layer[IDX_W-1:0];
  assign w_ld_ok   = ld_we && (r_state == OPEN) && (32'(ld_addr) < MEM_DEPTH);
  assign w_reject  = (tbl_we && !w_tbl_ok) || (ld_we && !w_ld_ok);

  // The sweep owns the RAM write port for the whole of ZEROIZE
  assign w_ram_we    = w_zero || w_ld_ok;
  assign w_ram_waddr = w_zero ? r_sweep : ld_addr;
  assign w_ram_wdata = w_zero ? 8'd0 : ld_data;

  cnn_param_ram #(.DEPTH(MEM_DEPTH), .AW(PHYS_W)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_phys[PHYS_W-1:0]),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= OPEN;
      r_sweep  <= '0;
      r_locked <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        OPEN: begin
          if (zeroize) begin
            r_state <= ZEROIZE;
            r_sweep <= '0;
            r_busy  <= 1'b1;
          end else if (lock) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (zeroize) begin
            r_state  <= ZEROIZE;
            r_sweep  <= '0;
            r_locked <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        ZEROIZE: begin
          r_sweep <= r_sweep + 1'b1;
          if (r_sweep == SWEEP_LAST) begin
            r_state <= OPEN;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state  <= OPEN;
          r_locked <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (w_zero && r_sweep == '0)) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_base[i] <= '0;
        r_len[i]  <= '0;
      end
    end else if (w_tbl_ok) begin
      r_base[w_tbl_idx] <= tbl_base;
      r_len[w_tbl_idx]  <= tbl_len;
    end
  end

  // Response stage: error flag is held with the RAM output so data_out
  // keeps the last response; it resets to 1 to force data_out to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1    <= 1'b0;
      r_err_p1    <= 1'b1;
      r_wr_reject <= 1'b0;
    end else begin
      r_vld_p1    <= rd_en;
      r_wr_reject <= w_reject;
      if (rd_en) r_err_p1 <= w_rd_err;
    end
  end

  assign data_out  = r_err_p1 ? 8'd0 : w_ram_q;
  assign rd_valid  = r_vld_p1;
  assign rd_err    = r_vld_p1 && r_err_p1;
  assign locked    = r_locked;
  assign busy      = r_busy;
  assign wr_reject = r_wr_reject;
endmodule

// File: tb/tb_cnn_param_store.sv
// Bench for cnn_param_store: directed vectors, multi-cycle lifecycle
// sequences, and randomized traffic checked against a behavioural model.
module tb_cnn_param_store;
  localparam int NL    = 24;
  localparam int DEPTH = 8192;
  localparam int PW    = 13;
  localparam int AW    = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_en = 1'b0;
  logic [5:0]    layer_select = '0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    data_out;
  logic          rd_valid, rd_err;
  logic          tbl_we = 1'b0;
  logic [5:0]    tbl_layer = '0;
  logic [PW-1:0] tbl_base = '0;
  logic [PW:0]   tbl_len = '0;
  logic          ld_we = 1'b0;
  logic [PW-1:0] ld_addr = '0;
  logic [7:0]    ld_data = '0;
  logic          lock = 1'b0;
  logic          zeroize = 1'b0;
  logic          locked, busy, wr_reject;

  cnn_param_store #(.NUM_LAYERS(NL), .MEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .layer_select(layer_select),
    .addr(addr), .data_out(data_out), .rd_valid(rd_valid), .rd_err(rd_err),
    .tbl_we(tbl_we), .tbl_layer(tbl_layer), .tbl_base(tbl_base),
    .tbl_len(tbl_len), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .lock(lock), .zeroize(zeroize), .locked(locked), .busy(busy),
    .wr_reject(wr_reject)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: 0 = open, 1 = locked, 2 = zeroizing
  int          m_state = 0;
  int          m_left  = 0;
  int unsigned m_base [NL];
  int unsigned m_len  [NL];
  logic [7:0]  m_mem  [DEPTH];
  bit          m_known[DEPTH];
  logic [7:0]  e_data = 8'd0;
  bit          e_dk = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    bit ev, ee, er;
    longint phys;
    ev = 1'b0; ee = 1'b0; er = 1'b0;
    if (reset) begin
      m_state = 0;
      for (int i = 0; i < NL; i++) begin m_base[i] = 0; m_len[i] = 0; end
      e_data = 8'd0; e_dk = 1'b1;
    end else begin
      ev = rd_en;
      if (rd_en) begin
        ee = (m_state == 2) || (layer_select >= NL);
        if (!ee) begin
          phys = longint'(m_base[layer_select]) + longint'(addr);
          ee = (addr >= m_len[layer_select]) || (phys >= DEPTH);
        end
        if (ee) begin
          e_data = 8'd0; e_dk = 1'b1;
        end else begin
          e_data = m_mem[int'(phys)]; e_dk = m_known[int'(phys)];
        end
      end
      er = (tbl_we && !(m_state == 0 && tbl_layer < NL)) || (ld_we && m_state != 0);
      if (m_state == 0 && tbl_we && tbl_layer < NL) begin
        m_base[tbl_layer] = tbl_base;
        m_len[tbl_layer]  = tbl_len;
      end
      if (m_state == 0 && ld_we) begin
        m_mem[ld_addr] = ld_data; m_known[ld_addr] = 1'b1;
      end
      case (m_state)
        0: if (zeroize) m_state = 2; else if (lock) m_state = 1;
        1: if (zeroize) m_state = 2;
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_state = 0;
            for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 8'd0; m_known[i] = 1'b1; end
          end
        end
      endcase
      if (m_state == 2 && m_left == 0) begin
        m_left = DEPTH;
        for (int i = 0; i < NL; i++) begin m_base[i] = 0; m_len[i] = 0; end
      end
    end
    @(posedge clk);
    #1;
    check("rd_valid", rd_valid, ev);
    check("rd_err", rd_err, ev & ee);
    if (e_dk) check("data_out", data_out, e_data);
    check("locked", locked, m_state == 1);
    check("busy", busy, m_state == 2);
    check("wr_reject", wr_reject, er);
    rd_en = 1'b0; tbl_we = 1'b0; ld_we = 1'b0; lock = 1'b0; zeroize = 1'b0;
  endtask

  task automatic wr_tbl(input int l, input int b, input int len);
    tbl_we = 1'b1; tbl_layer = 6'(l); tbl_base = PW'(b); tbl_len = (PW+1)'(len);
    tick();
  endtask

  task automatic wr_ld(input int a, input int d);
    ld_we = 1'b1; ld_addr = PW'(a); ld_data = 8'(d);
    tick();
  endtask

  task automatic rd(input int l, input int a);
    rd_en = 1'b1; layer_select = 6'(l); addr = AW'(a);
    tick();
  endtask

  typedef struct {
    int         lay;
    int         ad;
    logic       err;
    logic [7:0] data;
  } vec_t;
  vec_t vecs[12];

  initial begin
    int cnt;
    vecs[0]  = '{3, 'h10, 1'b0, 8'hA5};
    vecs[1]  = '{3, 256, 1'b1, 8'h00};
    vecs[2]  = '{24, 0, 1'b1, 8'h00};
    vecs[3]  = '{5, 8, 1'b1, 8'h00};
    vecs[4]  = '{5, 3, 1'b0, 8'h5C};
    vecs[5]  = '{3, 255, 1'b0, 8'h3C};
    vecs[6]  = '{7, 0, 1'b1, 8'h00};
    vecs[7]  = '{0, 8191, 1'b0, 8'h5C};
    vecs[8]  = '{0, 8192, 1'b1, 8'h00};
    vecs[9]  = '{63, 5, 1'b1, 8'h00};
    vecs[10] = '{5, 4, 1'b1, 8'h00};
    vecs[11] = '{3, 'h3FFFF, 1'b1, 8'h00};
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Load tables and payload while open
    wr_tbl(3, 'h1000, 256);
    wr_tbl(5, DEPTH - 4, 16);
    wr_tbl(0, 0, DEPTH);
    wr_tbl(7, 0, 0);
    wr_tbl(24, 0, 16);
    check("tbl_layer_oob_reject", wr_reject, 1'b1);
    wr_ld('h1010, 'hA5);
    wr_ld('h10FF, 'h3C);
    wr_ld(DEPTH - 1, 'h5C);
    for (int i = 0; i < 4; i++) wr_ld('h1000 + i, 'h10 + i);

    // Same-cycle write and read of one byte returns the old value
    ld_we = 1'b1; ld_addr = PW'('h1010); ld_data = 8'h77;
    rd(3, 'h10);
    check("collision_old", data_out, 8'hA5);
    rd(3, 'h10);
    check("collision_new", data_out, 8'h77);
    wr_ld('h1010, 'hA5);

    lock = 1'b1;
    tick();
    check("locked_rise", locked, 1'b1);

    foreach (vecs[i]) begin
      rd(vecs[i].lay, vecs[i].ad);
      check("vec_valid", rd_valid, 1'b1);
      check("vec_err", rd_err, vecs[i].err);
      check("vec_data", data_out, vecs[i].data);
    end

    // Writes while locked are dropped
    wr_ld('h1010, 'h00);
    check("ld_locked_reject", wr_reject, 1'b1);
    wr_tbl(3, 0, 16);
    check("tbl_locked_reject", wr_reject, 1'b1);
    rd(3, 'h10);
    check("locked_keep", data_out, 8'hA5);
    tick();
    check("data_hold", data_out, 8'hA5);

    for (int i = 0; i < 4; i++) begin
      rd(3, i);
      check("b2b_valid", rd_valid, 1'b1);
      check("b2b_data", data_out, 8'(8'h10 + i));
    end
    tick();
    check("b2b_end", rd_valid, 1'b0);

    // Zeroize beats lock; busy must last exactly DEPTH cycles
    zeroize = 1'b1; lock = 1'b1;
    tick();
    check("zero_busy", busy, 1'b1);
    check("zero_unlocked", locked, 1'b0);
    cnt = 0;
    for (int i = 0; i < DEPTH + 16 && busy; i++) begin
      cnt++;
      if (i == 50) zeroize = 1'b1;
      rd_en = 1'($urandom_range(0, 1)); layer_select = 6'd3;
      addr = AW'($urandom_range(0, 255));
      tick();
    end
    check("busy_cycles", cnt, DEPTH);
    check("post_zero_locked", locked, 1'b0);
    rd(3, 'h10);
    check("post_zero_err", rd_err, 1'b1);
    wr_tbl(3, 'h1000, 256);
    rd(3, 'h10);
    check("reload_err", rd_err, 1'b0);
    check("reload_data", data_out, 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rd_en = 1'($urandom_range(0, 1));
      layer_select = 6'($urandom_range(0, 26));
      addr = AW'($urandom_range(0, 300));
      if ($urandom_range(0, 9) == 0) begin
        tbl_we = 1'b1;
        tbl_layer = 6'($urandom_range(0, 26));
        tbl_base = ($urandom_range(0, 7) == 0) ? PW'($urandom_range(DEPTH - 200, DEPTH - 1))
                                               : PW'($urandom_range(0, 511));
        tbl_len = (PW+1)'($urandom_range(0, 400));
      end
      if ($urandom_range(0, 2) == 0) begin
        ld_we = 1'b1;
        ld_addr = PW'($urandom_range(0, 767));
        ld_data = 8'($urandom);
      end
      if (i > 500 && $urandom_range(0, 49) == 0) lock = 1'b1;
      tick();
    end

    // Reset in the middle of a sweep
    zeroize = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) tick();
    check("mid_busy", busy, 1'b1);
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_locked", locked, 1'b0);
    rd(3, 'h10);
    check("rst_rd_err", rd_err, 1'b1);
    rd(0, 0);
    check("rst_rd_err0", rd_err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
